// File: rtl/sader_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : sader_stream_if
// Description : Residual-in / SAD-result-out handshake bundle for sader_stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface sader_stream_if #(
    parameter int NMODES = 4,
    parameter int LANES  = 16,
    parameter int RES_W  = 9,
    parameter int SAD_W  = 16
);
    localparam int BM_W = ($clog2(NMODES) > 1) ? $clog2(NMODES) : 1;

    logic                            start;
    logic                            abort;
    logic                            in_valid;
    logic                            in_ready;
    logic [NMODES*LANES*RES_W-1:0]   res_in;
    logic                            out_valid;
    logic                            out_ready;
    logic [NMODES*SAD_W-1:0]         sads;
    logic [BM_W-1:0]                 best_mode;
    logic [SAD_W-1:0]                best_sad;
    logic                            busy;

    modport master (
        output start, abort, in_valid, res_in, out_ready,
        input  in_ready, out_valid, sads, best_mode, best_sad, busy
    );

    modport slave (
        input  start, abort, in_valid, res_in, out_ready,
        output in_ready, out_valid, sads, best_mode, best_sad, busy
    );
endinterface
`default_nettype wire

// File: rtl/sader_stream.sv
`default_nettype none
// ============================================================================
// Module      : sader_stream
// Description : Streams signed residuals for NMODES predictors, accumulates
//               saturating per-mode SADs over a block and picks the minimum.
// Revision    : 1.0 - initial release
// ============================================================================
module sader_stream #(
    parameter int NMODES  = 4,
    parameter int LANES   = 16,
    parameter int BLK_PIX = 256,
    parameter int RES_W   = 9,
    parameter int SAD_W   = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    sader_stream_if.slave  bus
);
    localparam int BM_W   = ($clog2(NMODES) > 1) ? $clog2(NMODES) : 1;
    localparam int BEATS  = BLK_PIX / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ABS_W  = RES_W + 1;
    localparam int BSUM_W = ABS_W + $clog2(LANES);
    localparam int SUM_W  = ((BSUM_W > SAD_W) ? BSUM_W : SAD_W) + 1;
    localparam logic [SUM_W-1:0] SAT = {{(SUM_W-SAD_W){1'b0}}, {SAD_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_CMP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SAD_W-1:0]   acc_q [NMODES];
    logic [SAD_W-1:0]   acc_d [NMODES];
    logic [SAD_W-1:0]   acc_sat [NMODES];
    logic [BM_W-1:0]    best_mode_q, best_mode_d, min_idx;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d, min_val;

    // Per-mode beat magnitude sum plus saturating add into the accumulator.
    for (genvar m = 0; m < NMODES; m++) begin : g_mode
        logic [RES_W-1:0]  r;
        logic [ABS_W-1:0]  ext;
        logic [ABS_W-1:0]  mag;
        logic [BSUM_W-1:0] bsum;
        logic [SUM_W-1:0]  tot;

        always_comb begin
            r    = '0;
            ext  = '0;
            mag  = '0;
            bsum = '0;
            for (int l = 0; l < LANES; l++) begin
                r    = bus.res_in[(m*LANES+l)*RES_W +: RES_W];
                ext  = {r[RES_W-1], r};
                mag  = r[RES_W-1] ? (~ext + ABS_W'(1)) : ext;
                bsum = bsum + BSUM_W'(mag);
            end
            tot        = SUM_W'(acc_q[m]) + SUM_W'(bsum);
            acc_sat[m] = (tot > SAT) ? {SAD_W{1'b1}} : tot[SAD_W-1:0];
        end

        assign bus.sads[m*SAD_W +: SAD_W] = acc_q[m];
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_val = acc_q[0];
        min_idx = '0;
        for (int m = 1; m < NMODES; m++) begin
            if (acc_q[m] < min_val) begin
                min_val = acc_q[m];
                min_idx = BM_W'(m);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_mode_d = best_mode_q;
        best_sad_d  = best_sad_q;
        for (int m = 0; m < NMODES; m++) acc_d[m] = acc_q[m];

        if (bus.abort) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            best_mode_d = '0;
            best_sad_d  = '0;
            for (int m = 0; m < NMODES; m++) acc_d[m] = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_ACCUM;
                        cnt_d   = '0;
                        for (int m = 0; m < NMODES; m++) acc_d[m] = '0;
                    end
                end
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        for (int m = 0; m < NMODES; m++) acc_d[m] = acc_sat[m];
                        if (cnt_q == CNT_W'(BEATS-1)) begin
                            cnt_d   = '0;
                            state_d = S_CMP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_CMP: begin
                    best_mode_d = min_idx;
                    best_sad_d  = min_val;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            for (int m = 0; m < NMODES; m++) acc_q[m] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_mode_q <= best_mode_d;
            best_sad_q  <= best_sad_d;
            for (int m = 0; m < NMODES; m++) acc_q[m] <= acc_d[m];
        end
    end

    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.best_mode = best_mode_q;
    assign bus.best_sad  = best_sad_q;

endmodule
`default_nettype wire

// File: tb/tb_sader_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_sader_stream
// Description : Directed self-checking bench for sader_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sader_stream;
    localparam int NM  = 4;
    localparam int LN  = 16;
    localparam int BP  = 256;
    localparam int RW  = 9;
    localparam int SW  = 16;
    localparam int BMW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sader_stream_if #(.NMODES(NM), .LANES(LN), .RES_W(RW), .SAD_W(SW)) bus();

    sader_stream #(.NMODES(NM), .LANES(LN), .BLK_PIX(BP), .RES_W(RW), .SAD_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [NM*LN*RW-1:0] mkres(input int v0, input int v1, input int v2, input int v3);
        logic [NM*LN*RW-1:0] r;
        int v;
        r = '0;
        for (int m = 0; m < NM; m++) begin
            v = (m == 0) ? v0 : (m == 1) ? v1 : (m == 2) ? v2 : v3;
            for (int l = 0; l < LN; l++) r[(m*LN+l)*RW +: RW] = RW'(v);
        end
        return r;
    endfunction

    function automatic logic [NM*SW-1:0] mksads(input int s0, input int s1, input int s2, input int s3);
        return {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
    endfunction

    // Stimulus helpers: all called at a falling edge, return at a falling edge.
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit gaps, output int sent);
        int cyc;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < 100) begin
            bus.in_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
            if (bus.in_valid && bus.in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.sads !== '0) begin bad++; $display("FAIL reset_sads got=%h exp=0", bus.sads); end
        total++; if ({bus.best_mode, bus.best_sad} !== '0) begin bad++; $display("FAIL reset_best got=%0d/%0d exp=0/0", bus.best_mode, bus.best_sad); end
        reset = 1'b0;
        bus.res_in   = mkres(1, 1, 1, 1);
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL no_start_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.sads !== '0) begin bad++; $display("FAIL no_start_sads got=%h exp=0", bus.sads); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_ramp();
        int sent;
        do_start();
        bus.res_in = mkres(1, 2, 3, 4);
        send_beats(16, 1'b0, sent);
        total++; if (sent !== 16) begin bad++; $display("FAIL ramp_beats got=%0d exp=16", sent); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ramp_cmp_cycle out_valid got=%b exp=0", bus.out_valid); end
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ramp_latency out_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.sads !== mksads(256, 512, 768, 1024)) begin bad++; $display("FAIL ramp_sads got=%h exp=%h", bus.sads, mksads(256, 512, 768, 1024)); end
        total++; if (bus.best_mode !== BMW'(0)) begin bad++; $display("FAIL ramp_best_mode got=%0d exp=0", bus.best_mode); end
        total++; if (bus.best_sad !== SW'(256)) begin bad++; $display("FAIL ramp_best_sad got=%0d exp=256", bus.best_sad); end
        consume();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ramp_idle busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_saturate();
        int sent, cyc;
        do_start();
        bus.res_in = mkres(-256, -256, -256, -256);
        send_beats(16, 1'b0, sent);
        wait_done(cyc);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sat_done got=%b exp=1", bus.out_valid); end
        total++; if (bus.sads !== mksads(65535, 65535, 65535, 65535)) begin bad++; $display("FAIL sat_sads got=%h exp=all ffff", bus.sads); end
        total++; if (bus.best_mode !== BMW'(0)) begin bad++; $display("FAIL sat_best_mode got=%0d exp=0", bus.best_mode); end
        total++; if (bus.best_sad !== SW'(65535)) begin bad++; $display("FAIL sat_best_sad got=%0d exp=65535", bus.best_sad); end
        consume();
    endtask

    task automatic test_tie();
        int sent, cyc;
        do_start();
        bus.res_in = mkres(-3, 2, -2, 2);
        send_beats(16, 1'b0, sent);
        wait_done(cyc);
        total++; if (bus.sads !== mksads(768, 512, 512, 512)) begin bad++; $display("FAIL tie_sads got=%h exp=%h", bus.sads, mksads(768, 512, 512, 512)); end
        total++; if (bus.best_mode !== BMW'(1)) begin bad++; $display("FAIL tie_best_mode got=%0d exp=1", bus.best_mode); end
        total++; if (bus.best_sad !== SW'(512)) begin bad++; $display("FAIL tie_best_sad got=%0d exp=512", bus.best_sad); end
        consume();
    endtask

    task automatic test_reset_mid();
        int sent, cyc;
        do_start();
        bus.res_in = mkres(1, 2, 3, 4);
        send_beats(7, 1'b0, sent);
        total++; if (bus.sads !== mksads(112, 224, 336, 448)) begin bad++; $display("FAIL rmid_partial got=%h exp=%h", bus.sads, mksads(112, 224, 336, 448)); end
        #2 reset = 1'b1;
        #1;
        total++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b000) begin bad++; $display("FAIL rmid_flags got=%b exp=000", {bus.busy, bus.in_ready, bus.out_valid}); end
        total++; if (bus.sads !== '0) begin bad++; $display("FAIL rmid_sads got=%h exp=0", bus.sads); end
        total++; if ({bus.best_mode, bus.best_sad} !== '0) begin bad++; $display("FAIL rmid_best got=%0d/%0d exp=0/0", bus.best_mode, bus.best_sad); end
        @(negedge clk);
        reset = 1'b0;
        do_start();
        send_beats(16, 1'b0, sent);
        wait_done(cyc);
        total++; if (bus.sads !== mksads(256, 512, 768, 1024)) begin bad++; $display("FAIL rmid_after_sads got=%h exp=%h", bus.sads, mksads(256, 512, 768, 1024)); end
        total++; if ({bus.best_mode, bus.best_sad} !== {BMW'(0), SW'(256)}) begin bad++; $display("FAIL rmid_after_best got=%0d/%0d exp=0/256", bus.best_mode, bus.best_sad); end
        consume();
    endtask

    task automatic test_abort();
        int sent, cyc;
        do_start();
        bus.res_in = mkres(-3, 2, -2, 2);
        send_beats(16, 1'b0, sent);
        wait_done(cyc);
        consume();
        total++; if (bus.best_mode !== BMW'(1)) begin bad++; $display("FAIL abort_pre_mode got=%0d exp=1", bus.best_mode); end
        do_start();
        bus.res_in = mkres(1, 2, 3, 4);
        send_beats(7, 1'b0, sent);
        bus.abort    = 1'b1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        #3;
        total++; if (bus.sads !== mksads(112, 224, 336, 448)) begin bad++; $display("FAIL abort_not_async got=%h exp=%h", bus.sads, mksads(112, 224, 336, 448)); end
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        total++; if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b000) begin bad++; $display("FAIL abort_flags got=%b exp=000", {bus.busy, bus.in_ready, bus.out_valid}); end
        total++; if (bus.sads !== '0) begin bad++; $display("FAIL abort_sads got=%h exp=0", bus.sads); end
        total++; if ({bus.best_mode, bus.best_sad} !== '0) begin bad++; $display("FAIL abort_best got=%0d/%0d exp=0/0", bus.best_mode, bus.best_sad); end
        do_start();
        send_beats(16, 1'b0, sent);
        wait_done(cyc);
        total++; if (bus.sads !== mksads(256, 512, 768, 1024)) begin bad++; $display("FAIL abort_after_sads got=%h exp=%h", bus.sads, mksads(256, 512, 768, 1024)); end
        total++; if ({bus.best_mode, bus.best_sad} !== {BMW'(0), SW'(256)}) begin bad++; $display("FAIL abort_after_best got=%0d/%0d exp=0/256", bus.best_mode, bus.best_sad); end
        consume();
    endtask

    task automatic test_gaps_hold();
        int sent, cyc;
        do_start();
        bus.res_in = mkres(1, 2, 3, 4);
        send_beats(16, 1'b1, sent);
        total++; if (sent !== 16) begin bad++; $display("FAIL gaps_beats got=%0d exp=16", sent); end
        bus.res_in = mkres(7, 7, 7, 7);
        wait_done(cyc);
        total++; if (bus.sads !== mksads(256, 512, 768, 1024)) begin bad++; $display("FAIL gaps_sads got=%h exp=%h", bus.sads, mksads(256, 512, 768, 1024)); end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            @(negedge clk);
            total++;
            if ({bus.out_valid, bus.sads, bus.best_mode, bus.best_sad} !== {1'b1, mksads(256, 512, 768, 1024), BMW'(0), SW'(256)}) begin
                bad++;
                $display("FAIL hold_cycle%0d got ov=%b sads=%h best=%0d/%0d exp ov=1 sads=%h best=0/256",
                         i, bus.out_valid, bus.sads, bus.best_mode, bus.best_sad, mksads(256, 512, 768, 1024));
            end
        end
        bus.in_valid  = 1'b0;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        total++; if ({bus.busy, bus.out_valid} !== 2'b00) begin bad++; $display("FAIL hold_release got busy/ov=%b exp=00", {bus.busy, bus.out_valid}); end
        total++; if (bus.sads !== mksads(256, 512, 768, 1024)) begin bad++; $display("FAIL no_chain_sads got=%h exp=%h", bus.sads, mksads(256, 512, 768, 1024)); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL no_chain_busy got=%b exp=0", bus.busy); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.res_in    = '0;
        test_reset();
        test_ramp();
        test_saturate();
        test_tie();
        test_reset_mid();
        test_abort();
        test_gaps_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
